demultiplexer_1_to_3_reg: RTL and testbench
===========================================

Name: demultiplexer_1_to_3_reg

Overview:
- Registered 1-to-3 demultiplexer; the routing counterpart of the 3-to-1 datapath mux.
- Accepts one word plus a 2-bit destination code over a valid/ready handshake.
- Holds the word in a single-entry register slice and presents it to exactly one of three consumers until that consumer accepts it.
- Used on the store/writeback side to steer a word to one of three sinks (e.g. data memory, GPIO, peripheral register). Reserved code 2'b11 is rejected and counted.

Parameters:
- N_BITS, 32, width of data word.
- ERR_CNT_BITS, 8, width of saturating reserved-selector error counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- selector_i  input  2  destination code: 00 -> dest 0, 01 -> dest 1, 10 -> dest 2, 11 reserved.
- data_i  input  N_BITS  word to route.
- valid_i  input  1  upstream word/selector valid.
- ready_o  output  1  block can accept a word this cycle.
- data_o  output  N_BITS  held word, shared by all three destinations.
- valid_0_o, valid_1_o, valid_2_o  output  1 each  held word is for destination k.
- ready_0_i, ready_1_i, ready_2_i  input  1 each  destination k accepts this cycle.
- error_o  output  1  one-cycle pulse: a reserved-selector word was consumed.
- error_count_o  output  ERR_CNT_BITS  saturating count of reserved-selector words.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to EMPTY; data_o=0; stored selector=00.
  - All valid_k_o=0; error_o=0; error_count_o=0.
  - A word held when reset asserts is discarded.
- FSM states:
  - EMPTY: nothing held.
  - FULL: word held in data_q/sel_q.
- Definitions:
  - out_fire = FULL && ready_{sel_q}_i. Ready inputs of non-selected destinations are ignored.
  - ready_o = EMPTY || out_fire. This is the only combinational input-to-output path; ready_o is allowed to depend on ready_k_i.
  - in_fire = valid_i && ready_o.
- Outputs:
  - valid_k_o = FULL && (sel_q == k). All valid outputs are decoded from registers only; at most one is ever high.
  - data_o is driven from data_q and holds stable while FULL and not out_fire.
- in_fire with selector_i in {00,01,10}:
  - data_q <= data_i and sel_q <= selector_i on the next edge.
  - Next state is FULL.
  - Latency is 1 cycle from in_fire to valid_k_o.
- in_fire with selector_i == 11:
  - The word is consumed but not stored.
  - error_o = 1 on the next cycle only.
  - error_count_o increments and saturates at all-ones.
  - Next state is EMPTY if out_fire occurred or the FSM was EMPTY.
- Simultaneous out_fire and in_fire with a valid selector:
  - The new word replaces the old one; state stays FULL.
  - Full throughput: one word per cycle.
- out_fire without in_fire: next state is EMPTY.
- FULL without out_fire: everything is held; ready_o=0, so upstream stalls.
- valid_i=0 when the block is ready: no state change.
- Back-to-back reserved codes: error_o stays high for consecutive cycles, and the count increments once per word.

Decomposition:
- Shared package demux_pkg:
  - Selector constants SEL_DEST0=2'b00, SEL_DEST1=2'b01, SEL_DEST2=2'b10, SEL_RESERVED=2'b11.
  - FSM state encoding: EMPTY=1'b0, FULL=1'b1.
- One sub-module is natural: saturating_counter, with parameters WIDTH and inputs clk, reset, inc_i, and output count_o. It is used for error_count_o.

Test Plan:
- Reset: hold reset=0 with valid_i=1 -> ready_o=1, all valid_k_o=0, data_o=0, error_count_o=0. Release reset -> no spurious output.
- Single route: data_i=32'hDEADBEEF, selector_i=01, valid_i=1 for one cycle, ready_1_i=1 -> next cycle valid_1_o=1, data_o=DEADBEEF, valid_0_o=valid_2_o=0. The cycle after, all valid outputs are 0.
- Stall/hold: load 32'h0000_00A5 to dest 2 with ready_2_i=0 for 5 cycles and ready_0_i=ready_1_i=1:
  - valid_2_o stays 1 and data_o stays A5.
  - ready_o=0 throughout; upstream word 32'h1234 is held off.
  - Raising ready_2_i -> 1234 is accepted that same cycle.
- Streaming: 4 words 1,2,3,4 with selectors 00,01,10,00, all ready_k_i=1 -> one word per cycle, routed 1->0, 2->1, 3->2, 4->0, with no bubbles.
- Reserved selector: selector_i=11 with data 32'hFFFF, then a valid word -> error_o pulses for exactly 1 cycle, error_count_o=1, no valid_k_o for FFFF. After 300 reserved words with ERR_CNT_BITS=8 -> count saturates at 255.
- Reset mid-operation: FULL with valid_0_o=1 and ready_0_i=0; assert reset asynchronously mid-cycle -> valid_0_o drops immediately, data_o=0. After release the block is EMPTY.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared selector codes, FSM encoding and selector helper for the registered 1-to-3 demultiplexer.
package demux_pkg;

    localparam logic [1:0] SEL_DEST0    = 2'b00;
    localparam logic [1:0] SEL_DEST1    = 2'b01;
    localparam logic [1:0] SEL_DEST2    = 2'b10;
    localparam logic [1:0] SEL_RESERVED = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    function automatic logic sel_is_reserved(input logic [1:0] sel);
        return (sel == SEL_RESERVED);
    endfunction

endpackage

// File: rtl/demultiplexer_1_to_3_reg_saturating_counter.sv
// Up-counter that sticks at all-ones; counts reserved-selector words for the demultiplexer.
module saturating_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count;

    // Count register: increments on request until it reaches all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= {WIDTH{1'b0}};
        end else if (inc_i && (r_count != ALL_ONES)) begin
            r_count <= r_count + ONE;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/demultiplexer_1_to_3_reg.sv
// Registered 1-to-3 demultiplexer: single-entry slice steering a word to one of three sinks,
// rejecting and counting the reserved destination code.
module demultiplexer_1_to_3_reg #(
    parameter int N_BITS       = 32,
    parameter int ERR_CNT_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              selector_i,
    input  logic [N_BITS-1:0]       data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [N_BITS-1:0]       data_o,
    output logic                    valid_0_o,
    output logic                    valid_1_o,
    output logic                    valid_2_o,
    input  logic                    ready_0_i,
    input  logic                    ready_1_i,
    input  logic                    ready_2_i,
    output logic                    error_o,
    output logic [ERR_CNT_BITS-1:0] error_count_o
);

    import demux_pkg::*;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_BITS-1:0] r_data;
    logic [N_BITS-1:0] w_data_nxt;
    logic [1:0]        r_sel;
    logic [1:0]        w_sel_nxt;
    logic              r_error;
    logic              w_sel_ready;
    logic              w_out_fire;
    logic              w_in_fire;
    logic              w_in_store;
    logic              w_in_err;

    // Only the ready of the destination currently held matters; the others are ignored.
    always_comb begin
        w_sel_ready = 1'b0;
        case (r_sel)
            SEL_DEST0: w_sel_ready = ready_0_i;
            SEL_DEST1: w_sel_ready = ready_1_i;
            SEL_DEST2: w_sel_ready = ready_2_i;
            default:   w_sel_ready = 1'b0;
        endcase
    end

    assign w_out_fire = (r_state == ST_FULL) && w_sel_ready;
    assign ready_o    = (r_state == ST_EMPTY) || w_out_fire;
    assign w_in_fire  = valid_i && ready_o;
    assign w_in_store = w_in_fire && !sel_is_reserved(selector_i);
    assign w_in_err   = w_in_fire && sel_is_reserved(selector_i);

    // State, word and selector registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
            r_data  <= {N_BITS{1'b0}};
            r_sel   <= SEL_DEST0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // Next-state: a stored word wins over a drain, so a simultaneous drain+fill stays FULL.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_sel_nxt   = r_sel;
        if (w_in_store) begin
            w_state_nxt = ST_FULL;
            w_data_nxt  = data_i;
            w_sel_nxt   = selector_i;
        end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Error pulse follows each consumed reserved word by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_error <= 1'b0;
        end else begin
            r_error <= w_in_err;
        end
    end

    saturating_counter #(
        .WIDTH (ERR_CNT_BITS)
    ) u_err_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (w_in_err),
        .count_o (error_count_o)
    );

    assign data_o    = r_data;
    assign error_o   = r_error;
    assign valid_0_o = (r_state == ST_FULL) && (r_sel == SEL_DEST0);
    assign valid_1_o = (r_state == ST_FULL) && (r_sel == SEL_DEST1);
    assign valid_2_o = (r_state == ST_FULL) && (r_sel == SEL_DEST2);

endmodule

// File: tb/tb_demultiplexer_1_to_3_reg.sv
// Scoreboard bench for demultiplexer_1_to_3_reg: driver pushes expected routing/error events, monitor pops and compares.
module tb_demultiplexer_1_to_3_reg;

    typedef struct {
        logic [1:0]  dest;
        logic [31:0] data;
    } item_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  selector_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_o;
    logic        valid_0_o, valid_1_o, valid_2_o;
    logic        ready_0_i, ready_1_i, ready_2_i;
    logic        error_o;
    logic [7:0]  error_count_o;

    item_t  exp_q[$];
    logic   err_q[$];
    int     cnt_q[$];
    int     exp_cnt;
    int     n_cmp;
    int     n_err;
    logic   mon_en;

    demultiplexer_1_to_3_reg #(.N_BITS(32), .ERR_CNT_BITS(8)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .selector_i    (selector_i),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .data_o        (data_o),
        .valid_0_o     (valid_0_o),
        .valid_1_o     (valid_1_o),
        .valid_2_o     (valid_2_o),
        .ready_0_i     (ready_0_i),
        .ready_1_i     (ready_1_i),
        .ready_2_i     (ready_2_i),
        .error_o       (error_o),
        .error_count_o (error_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic dest_ready(input logic [1:0] d);
        return (d == 2'd0) ? ready_0_i : (d == 2'd1) ? ready_1_i : (d == 2'd2) ? ready_2_i : 1'b0;
    endfunction

    // One cycle of stimulus: drive at negedge, record what the reference expects after the coming edge.
    task automatic cycle(input logic v, input logic [1:0] sel, input logic [31:0] d,
                         input logic r0, input logic r1, input logic r2);
        item_t it;
        logic  rsv_fire;
        @(negedge clk);
        valid_i = v; selector_i = sel; data_i = d;
        ready_0_i = r0; ready_1_i = r1; ready_2_i = r2;
        #2;
        rsv_fire = 1'b0;
        if (v && ready_o) begin
            if (sel == 2'b11) begin
                rsv_fire = 1'b1;
            end else begin
                it.dest = sel; it.data = d;
                exp_q.push_back(it);
            end
        end
        if (rsv_fire) exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
        err_q.push_back(rsv_fire);
        cnt_q.push_back(exp_cnt);
    endtask

    // Monitor: compares handshake, routing and error outputs against the scoreboard.
    initial begin
        logic [2:0] vv;
        logic [2:0] exp_vv;
        logic       exp_rdy;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                vv = {valid_2_o, valid_1_o, valid_0_o};
                exp_rdy = (exp_q.size() == 0) ? 1'b1 : dest_ready(exp_q[0].dest);
                chk("ready_o", {63'd0, ready_o}, {63'd0, exp_rdy});
                if (exp_q.size() == 0) begin
                    chk("valid_idle", {61'd0, vv}, 64'd0);
                end else begin
                    exp_vv = 3'b001 << exp_q[0].dest;
                    chk("valid_route", {61'd0, vv}, {61'd0, exp_vv});
                    chk("data_o", {32'd0, data_o}, {32'd0, exp_q[0].data});
                    if (dest_ready(exp_q[0].dest)) void'(exp_q.pop_front());
                end
                if (err_q.size() > 0) begin
                    chk("error_o", {63'd0, error_o}, {63'd0, err_q.pop_front()});
                    chk("error_count", {56'd0, error_count_o}, 64'(cnt_q.pop_front()));
                end
            end
        end
    end

    initial begin
        n_cmp = 0; n_err = 0; exp_cnt = 0; mon_en = 1'b0;
        rst_n = 1'b0; valid_i = 1'b1; selector_i = 2'b01; data_i = 32'h5555_AAAA;
        ready_0_i = 1'b1; ready_1_i = 1'b1; ready_2_i = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_ready", {63'd0, ready_o}, 64'd1);
        chk("rst_valids", {61'd0, valid_2_o, valid_1_o, valid_0_o}, 64'd0);
        chk("rst_data", {32'd0, data_o}, 64'd0);
        chk("rst_count", {56'd0, error_count_o}, 64'd0);
        chk("rst_error", {63'd0, error_o}, 64'd0);
        @(negedge clk);
        valid_i = 1'b0;
        rst_n = 1'b1;
        mon_en = 1'b1;
        cycle(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);

        // Single route to destination 1
        cycle(1'b1, 2'b01, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);

        // Stall on destination 2 while upstream offers 0x1234
        cycle(1'b1, 2'b10, 32'h0000_00A5, 1'b1, 1'b1, 1'b0);
        repeat (5) cycle(1'b1, 2'b00, 32'h0000_1234, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 2'b00, 32'h0000_1234, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);

        // Streaming without bubbles
        cycle(1'b1, 2'b00, 32'd1, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 2'b01, 32'd2, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 2'b10, 32'd3, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 2'b00, 32'd4, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);

        // Reserved code followed by a routed word
        cycle(1'b1, 2'b11, 32'h0000_FFFF, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 2'b00, 32'h0000_0005, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end

        // Saturate the error counter
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 2'b11, $urandom, 1'b1, 1'b1, 1'b1);
        end
        cycle(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("count_saturated", {56'd0, error_count_o}, 64'd255);

        // Asynchronous reset while a word is held for a stalled destination 0
        cycle(1'b1, 2'b00, 32'hCAFE_0001, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid0", {63'd0, valid_0_o}, 64'd0);
        chk("midrst_data", {32'd0, data_o}, 64'd0);
        chk("midrst_count", {56'd0, error_count_o}, 64'd0);
        exp_q.delete(); err_q.delete(); cnt_q.delete(); exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        cycle(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'b10, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
